// File: rtl/mdu_iter_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Multiplies by shift-add and divides by restoring division, one bit per clock.
//
// state | meaning
// IDLE  | waiting for an M-extension issue, in_ready high
// RUN   | iterating; one extra cycle after the last bit loads the sign-fixed result
// DONE  | result presented, waiting for out_ready
module mdu_iter_unit #(
  parameter int XLEN         = 32,
  parameter int TAG_WIDTH    = 5,
  parameter int EARLY_OUT    = 1,
  parameter int OPCODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH = 3,
  parameter int FUNCT7_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNCT3_WIDTH-1:0] funct3,
  input  logic [FUNCT7_WIDTH-1:0] funct7,
  input  logic [XLEN-1:0]         rs1_val,
  input  logic [XLEN-1:0]         rs2_val,
  input  logic [TAG_WIDTH-1:0]    rd_tag,
  output logic                    is_mdu,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         result,
  output logic [TAG_WIDTH-1:0]    out_tag
);

  localparam int CW = $clog2(XLEN);
  localparam logic [OPCODE_WIDTH-1:0] OP_OP  = OPCODE_WIDTH'(7'b0110011);
  localparam logic [FUNCT7_WIDTH-1:0] F7_MDU = FUNCT7_WIDTH'(7'b0000001);
  localparam logic [XLEN-1:0]         X_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic                  iter_done_q;
  logic [2:0]            f3_q;
  logic [XLEN-1:0]       hi_q, lo_q, m_q, a_raw_q;
  logic                  neg_q, div0_q, ovf_q;
  logic [TAG_WIDTH-1:0]  tag_q;

  logic                  accept;
  logic                  is_div_in, a_sgn_in, b_sgn_in, a_neg, b_neg, neg_in;
  logic [XLEN-1:0]       a_mag, b_mag;
  logic [XLEN:0]         mul_sum, div_shift;
  logic                  div_ge;
  logic [XLEN-1:0]       div_diff, div_val, div_fix, res_d;
  logic [2*XLEN-1:0]     prod, prod_fix;

  assign is_mdu    = (opcode == OP_OP) && (funct7 == F7_MDU);
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid & in_ready & is_mdu & ~flush;

  // Operand signedness: DIV/REM signed both; MULH both; MULHSU only rs1.
  assign is_div_in = funct3[2];
  assign a_sgn_in  = is_div_in ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign b_sgn_in  = is_div_in ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign a_neg     = a_sgn_in & rs1_val[XLEN-1];
  assign b_neg     = b_sgn_in & rs2_val[XLEN-1];
  assign a_mag     = a_neg ? -rs1_val : rs1_val;
  assign b_mag     = b_neg ? -rs2_val : rs2_val;
  assign neg_in    = (is_div_in && funct3[1]) ? a_neg : (a_neg ^ b_neg);

  // hi/lo double as product halves for multiply and remainder/quotient for divide.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, m_q};
  assign div_diff  = div_shift[XLEN-1:0] - m_q;

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign div_val  = f3_q[1] ? hi_q : lo_q;
  assign div_fix  = neg_q ? -div_val : div_val;

  always_comb begin
    res_d = div_fix;
    if (!f3_q[2])
      res_d = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (div0_q)
      res_d = f3_q[1] ? a_raw_q : '1;
    else if (ovf_q)
      res_d = f3_q[1] ? '0 : a_raw_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (iter_done_q) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      iter_done_q <= 1'b0;
      f3_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      m_q         <= '0;
      a_raw_q     <= '0;
      neg_q       <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      tag_q       <= '0;
      result      <= '0;
      out_tag     <= '0;
    end else if (accept) begin
      cnt_q       <= CW'(XLEN-1);
      iter_done_q <= 1'b0;
      f3_q        <= funct3[2:0];
      hi_q        <= '0;
      lo_q        <= is_div_in ? a_mag : b_mag;
      m_q         <= is_div_in ? b_mag : a_mag;
      a_raw_q     <= rs1_val;
      neg_q       <= neg_in;
      div0_q      <= is_div_in && (rs2_val == '0);
      ovf_q       <= is_div_in && !funct3[0] && (rs1_val == X_MIN) && (rs2_val == '1);
      tag_q       <= rd_tag;
    end else if (state_q == S_RUN && !flush) begin
      if (iter_done_q) begin
        result  <= res_d;
        out_tag <= tag_q;
      end else if (EARLY_OUT != 0 && (div0_q || ovf_q)) begin
        iter_done_q <= 1'b1;
      end else begin
        if (f3_q[2]) begin
          hi_q <= div_ge ? div_diff : div_shift[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_q <= mul_sum[XLEN:1];
          lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == '0) iter_done_q <= 1'b1;
        else             cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule
